// File: rtl/stream_sorter.sv
// rtl/stream_sorter.sv - AXI-Lite configured streaming sorter using an odd-even transposition network
module stream_sorter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);
    localparam int CW = $clog2(pDEPTH + 1);
    localparam int IW = $clog2(pDEPTH);
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_MODE = pADDR_WIDTH'('h14);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;

    state_t                 state;
    logic                   ap_done;
    logic                   ap_idle;
    logic [CW-1:0]          len;
    logic [1:0]             mode;
    logic [pDATA_WIDTH-1:0] slot    [pDEPTH];
    logic [pDATA_WIDTH-1:0] swapped [pDEPTH];
    logic [CW-1:0]          count;
    logic [CW-1:0]          n;
    logic [CW-1:0]          k;
    logic [CW-1:0]          rd;
    logic                   rd_ctrl;
    logic                   wr_fire;
    logic [pDATA_WIDTH-1:0] read_word;

    function automatic logic out_of_order(input logic [pDATA_WIDTH-1:0] a,
                                          input logic [pDATA_WIDTH-1:0] b,
                                          input logic [1:0] m);
        logic gt;
        logic lt;
        if (m[1]) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return m[0] ? lt : gt;
    endfunction

    assign wr_fire   = awvalid & wvalid;
    assign awready   = wr_fire;
    assign wready    = wr_fire;
    assign arready   = arvalid & ~rvalid;
    assign ss_tready = (state == LOAD) && (count < len);
    assign sm_tvalid = (state == DRAIN);
    assign sm_tdata  = sm_tvalid ? slot[rd[IW-1:0]] : '0;
    assign sm_tlast  = sm_tvalid && (rd == n - CW'(1));

    always_comb begin
        read_word = '0;
        case (araddr)
            ADDR_CTRL: read_word = pDATA_WIDTH'({ap_idle, ap_done, 1'b0});
            ADDR_LEN:  read_word = pDATA_WIDTH'(len);
            ADDR_MODE: read_word = pDATA_WIDTH'(mode);
            default:   read_word = '0;
        endcase
    end

    // One transposition phase: pairs are disjoint, so all swaps read the pre-phase array.
    always_comb begin
        swapped = slot;
        for (int i = 0; i < pDEPTH - 1; i++) begin
            if ((i[0] == k[0]) && (i + 1 < int'(n)) && out_of_order(slot[i], slot[i+1], mode)) begin
                swapped[i]   = slot[i+1];
                swapped[i+1] = slot[i];
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state   <= IDLE;
            ap_done <= 1'b0;
            ap_idle <= 1'b1;
            len     <= CW'(pDEPTH);
            mode    <= 2'b00;
            count   <= '0;
            n       <= '0;
            k       <= '0;
            rd      <= '0;
            rd_ctrl <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            for (int i = 0; i < pDEPTH; i++) slot[i] <= '0;
        end else begin
            if (arvalid && arready) begin
                rvalid  <= 1'b1;
                rdata   <= read_word;
                rd_ctrl <= (araddr == ADDR_CTRL);
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
                if (rd_ctrl) ap_done <= 1'b0;
            end

            if (wr_fire && state == IDLE) begin
                if (awaddr == ADDR_LEN) begin
                    if (wdata == '0)                            len <= CW'(1);
                    else if (wdata > pDATA_WIDTH'(pDEPTH))      len <= CW'(pDEPTH);
                    else                                        len <= wdata[CW-1:0];
                end
                if (awaddr == ADDR_MODE) mode <= wdata[1:0];
            end

            // Later assignments here override the clear-on-read above, so a done-set wins.
            case (state)
                IDLE: begin
                    if (wr_fire && awaddr == ADDR_CTRL && wdata[0]) begin
                        state   <= LOAD;
                        ap_idle <= 1'b0;
                        ap_done <= 1'b0;
                        count   <= '0;
                    end
                end
                LOAD: begin
                    if (ss_tvalid && ss_tready) begin
                        slot[count[IW-1:0]] <= ss_tdata;
                        count <= count + CW'(1);
                        if (ss_tlast || (count + CW'(1) == len)) begin
                            state <= SORT;
                            n     <= count + CW'(1);
                            k     <= '0;
                        end
                    end
                end
                SORT: begin
                    slot <= swapped;
                    k    <= k + CW'(1);
                    if (k == n - CW'(1)) begin
                        state <= DRAIN;
                        rd    <= '0;
                    end
                end
                DRAIN: begin
                    if (sm_tready) begin
                        if (rd == n - CW'(1)) begin
                            state   <= IDLE;
                            ap_done <= 1'b1;
                            ap_idle <= 1'b1;
                        end else begin
                            rd <= rd + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_sorter.sv
// tb/tb_stream_sorter.sv - randomized bench for stream_sorter against a key-ordering sort model
module tb_stream_sorter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    typedef logic [DW-1:0] word_q[$];

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b1;
    logic          awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
    logic          awready, wready, arready, rvalid;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [DW-1:0] wdata = '0, rdata;
    logic          ss_tvalid = 0, ss_tlast = 0, ss_tready;
    logic [DW-1:0] ss_tdata = '0;
    logic          sm_tvalid, sm_tlast, sm_tready = 0;
    logic [DW-1:0] sm_tdata;

    int checks = 0;
    int errors = 0;
    int ss_beats = 0;

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) if (ss_tvalid && ss_tready) ss_beats <= ss_beats + 1;

    stream_sorter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    // Ordering key: signed maps to unsigned by flipping the sign bit, descending by inversion.
    function automatic logic [DW-1:0] sort_key(input logic [DW-1:0] v, input logic [1:0] m);
        logic [DW-1:0] kv;
        kv = v;
        if (m[1]) kv[DW-1] = ~kv[DW-1];
        return m[0] ? ~kv : kv;
    endfunction

    function automatic word_q model_sort(input word_q d, input logic [1:0] m);
        word_q r;
        logic [DW-1:0] tmp;
        r = d;
        for (int i = 0; i < r.size(); i++)
            for (int j = i + 1; j < r.size(); j++)
                if (sort_key(r[j], m) < sort_key(r[i], m)) begin
                    tmp = r[i]; r[i] = r[j]; r[j] = tmp;
                end
        return r;
    endfunction

    function automatic int first_diff(input word_q a, input word_q b);
        if (a.size() != b.size()) return -2;
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic axil_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge axis_clk);
        awvalid = 1; wvalid = 1; awaddr = a; wdata = d;
        @(negedge axis_clk);
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axil_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit to);
        int t;
        t = 0; to = 0; d = '0;
        @(negedge axis_clk);
        arvalid = 1; araddr = a;
        #1;
        while (!arready && t < 20) begin @(negedge axis_clk); #1; t++; end
        @(negedge axis_clk);
        arvalid = 0;
        while (!rvalid && t < 40) begin @(negedge axis_clk); t++; end
        if (t >= 40 || !rvalid) to = 1;
        d = rdata;
        rready = 1;
        @(negedge axis_clk);
        rready = 0;
    endtask

    task automatic send_beats(input word_q d, input int last_at, output int acc, output bit to);
        int t;
        acc = 0; to = 0;
        foreach (d[j]) begin
            @(negedge axis_clk);
            ss_tvalid = 1; ss_tdata = d[j]; ss_tlast = (j == last_at);
            t = 0;
            while (!ss_tready && t < 50) begin @(negedge axis_clk); t++; end
            if (t >= 50) begin to = 1; break; end
            @(posedge axis_clk);
            acc++;
        end
        @(negedge axis_clk);
        ss_tvalid = 0; ss_tlast = 0;
    endtask

    task automatic recv_beats(input int n, input int pct, output word_q got, output int last_idx,
                              output int last_cnt, output bit stable_ok, output bit to);
        int t;
        bit hold;
        logic [DW-1:0] prev;
        got = {}; last_idx = -1; last_cnt = 0; stable_ok = 1; to = 0; t = 0; hold = 0; prev = '0;
        while (got.size() < n && t < 3000) begin
            @(negedge axis_clk);
            if (hold && (!sm_tvalid || sm_tdata !== prev)) stable_ok = 0;
            sm_tready = ($urandom_range(99) < pct);
            if (sm_tvalid && sm_tready) begin
                got.push_back(sm_tdata);
                if (sm_tlast) begin last_idx = got.size() - 1; last_cnt++; end
                hold = 0;
            end else begin
                hold = sm_tvalid; prev = sm_tdata;
            end
            t++;
        end
        if (got.size() < n) to = 1;
        @(posedge axis_clk);
        @(negedge axis_clk);
        sm_tready = 0;
    endtask

    task automatic wait_first_out(output int cyc);
        cyc = 1;
        while (!sm_tvalid && cyc < 100) begin @(negedge axis_clk); cyc++; end
    endtask

    task automatic run_random_job(input string name, input int len, input logic [1:0] m, input int pct);
        word_q d, got, exp;
        int acc, li, lc, diff;
        bit to1, to2, st;
        for (int i = 0; i < len; i++) d.push_back($urandom_range(3) == 0 ? DW'($urandom_range(3)) : $urandom);
        exp = model_sort(d, m);
        axil_write('h10, len);
        axil_write('h14, m);
        axil_write('h00, 1);
        send_beats(d, -1, acc, to1);
        recv_beats(len, pct, got, li, lc, st, to2);
        diff = first_diff(got, exp);
        checks++;
        if (to1 || to2 || acc != len) begin
            errors++; $display("FAIL %s_flow acc=%0d to=%0d/%0d expected acc=%0d", name, acc, to1, to2, len);
        end
        checks++;
        if (diff != -1) begin
            errors++; $display("FAIL %s_data first_diff=%0d got_size=%0d expected sorted size %0d", name, diff, got.size(), len);
        end
        checks++;
        if (li != len - 1 || lc != 1 || !st) begin
            errors++; $display("FAIL %s_tlast_stable last_idx=%0d cnt=%0d stable=%0d expected %0d/1/1", name, li, lc, st, len - 1);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        bit to;
        axis_rst_n = 1; #2; axis_rst_n = 0; #1;
        checks++;
        if ({ss_tready, sm_tvalid, sm_tlast, rvalid, arready, awready} !== 6'b0 || sm_tdata !== '0 || rdata !== '0) begin
            errors++; $display("FAIL reset_outputs got %b %h %h expected zeros",
                {ss_tready, sm_tvalid, sm_tlast, rvalid, arready, awready}, sm_tdata, rdata);
        end
        repeat (3) @(negedge axis_clk);
        axis_rst_n = 1;
        axil_read('h00, v, to);
        checks++; if (v !== 32'h4 || to) begin errors++; $display("FAIL reset_ctrl got %h expected 4", v); end
        axil_read('h10, v, to);
        checks++; if (v !== DEPTH) begin errors++; $display("FAIL reset_len got %0d expected %0d", v, DEPTH); end
        axil_read('h14, v, to);
        checks++; if (v !== 0) begin errors++; $display("FAIL reset_mode got %0d expected 0", v); end
        axil_read('h20, v, to);
        checks++; if (v !== 0) begin errors++; $display("FAIL unmapped_read got %h expected 0", v); end
    endtask

    task automatic test_basic();
        word_q d, got, exp;
        logic [DW-1:0] v;
        int acc, li, lc, cyc;
        bit to, to2, st;
        d = '{32'd7, 32'd3, 32'd9, 32'd1};
        exp = '{32'd1, 32'd3, 32'd7, 32'd9};
        axil_write('h10, 4);
        axil_write('h14, 0);
        axil_write('h00, 1);
        axil_read('h00, v, to);
        checks++; if (v !== 0) begin errors++; $display("FAIL basic_ctrl_busy got %h expected 0", v); end
        send_beats(d, -1, acc, to);
        wait_first_out(cyc);
        checks++; if (cyc != 5) begin errors++; $display("FAIL basic_latency got %0d expected 5", cyc); end
        recv_beats(4, 100, got, li, lc, st, to2);
        checks++;
        if (first_diff(got, exp) != -1 || to || to2) begin
            errors++; $display("FAIL basic_data first_diff=%0d expected -1", first_diff(got, exp));
        end
        checks++; if (li != 3 || lc != 1) begin errors++; $display("FAIL basic_tlast got idx %0d cnt %0d expected 3/1", li, lc); end
        axil_read('h00, v, to);
        checks++; if (v !== 32'h6) begin errors++; $display("FAIL basic_done got %h expected 6", v); end
        axil_read('h00, v, to);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL basic_done_cleared got %h expected 4", v); end
    endtask

    task automatic test_signed_desc();
        word_q d, got, exp;
        int acc, li, lc;
        bit to, to2, st;
        for (int i = 0; i < 16; i++) d.push_back(i);
        d[3] = 32'hFFFF_FFFB;
        exp = model_sort(d, 2'b11);
        axil_write('h10, 16);
        axil_write('h14, 3);
        axil_write('h00, 1);
        send_beats(d, -1, acc, to);
        recv_beats(16, 100, got, li, lc, st, to2);
        checks++;
        if (first_diff(got, exp) != -1 || to || to2) begin
            errors++; $display("FAIL sdesc_data first_diff=%0d expected -1", first_diff(got, exp));
        end
        checks++;
        if (got.size() != 16 || got[0] !== 32'd15 || got[15] !== 32'hFFFF_FFFB || li != 15) begin
            errors++; $display("FAIL sdesc_ends got size %0d last_idx %0d expected 15 first, FFFFFFFB last", got.size(), li);
        end
    endtask

    task automatic test_early_tlast();
        word_q d, got, exp;
        int acc, li, lc, cyc, base;
        bit to, to2, st;
        d = '{32'd5, 32'd5, 32'd2};
        exp = '{32'd2, 32'd5, 32'd5};
        axil_write('h10, 8);
        axil_write('h14, 0);
        axil_write('h00, 1);
        base = ss_beats;
        send_beats(d, 2, acc, to);
        @(negedge axis_clk);
        ss_tvalid = 1; ss_tdata = 32'hDEAD; ss_tlast = 0;
        wait_first_out(cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL early_latency got %0d expected 3", cyc); end
        recv_beats(3, 100, got, li, lc, st, to2);
        ss_tvalid = 0;
        checks++;
        if (first_diff(got, exp) != -1 || to || to2 || li != 2) begin
            errors++; $display("FAIL early_data first_diff=%0d last_idx=%0d expected -1/2", first_diff(got, exp), li);
        end
        checks++;
        if (ss_beats - base != 3) begin
            errors++; $display("FAIL early_extra_beat accepted %0d beats expected 3", ss_beats - base);
        end
    endtask

    task automatic test_len_regs();
        word_q d, got, exp;
        logic [DW-1:0] v;
        int acc, li, lc, cyc;
        bit to, to2, st;
        axil_write('h10, 0);
        axil_read('h10, v, to);
        checks++; if (v !== 1) begin errors++; $display("FAIL len_zero got %0d expected 1", v); end
        axil_write('h10, 99);
        axil_read('h10, v, to);
        checks++; if (v !== DEPTH) begin errors++; $display("FAIL len_big got %0d expected %0d", v, DEPTH); end
        d = '{32'd40, 32'd20};
        exp = '{32'd20, 32'd40};
        axil_write('h10, 2);
        axil_write('h14, 0);
        axil_write('h00, 1);
        send_beats(d, -1, acc, to);
        wait_first_out(cyc);
        axil_write('h10, 5);
        axil_write('h14, 3);
        axil_read('h10, v, to);
        checks++; if (v !== 2) begin errors++; $display("FAIL len_drain_write got %0d expected 2", v); end
        axil_read('h14, v, to);
        checks++; if (v !== 0) begin errors++; $display("FAIL mode_drain_write got %0d expected 0", v); end
        recv_beats(2, 100, got, li, lc, st, to2);
        checks++;
        if (first_diff(got, exp) != -1 || to2) begin
            errors++; $display("FAIL len_drain_data first_diff=%0d expected -1", first_diff(got, exp));
        end
    endtask

    task automatic test_back_to_back();
        run_random_job("bp16", 16, 2'($urandom_range(3)), 50);
        run_random_job("bp1", 1, 2'b00, 50);
        for (int j = 0; j < 3; j++) run_random_job("rnd", $urandom_range(2, 16), 2'($urandom_range(3)), 60);
    endtask

    task automatic test_reset_mid_sort();
        word_q d;
        logic [DW-1:0] v;
        int acc;
        bit to;
        for (int i = 0; i < 16; i++) d.push_back($urandom);
        axil_write('h10, 16);
        axil_write('h14, 1);
        axil_write('h00, 1);
        send_beats(d, -1, acc, to);
        repeat (3) @(negedge axis_clk);
        axis_rst_n = 0; #1;
        checks++;
        if ({ss_tready, sm_tvalid, sm_tlast, rvalid} !== 4'b0 || sm_tdata !== '0) begin
            errors++; $display("FAIL midsort_outputs got %b %h expected zeros", {ss_tready, sm_tvalid, sm_tlast, rvalid}, sm_tdata);
        end
        @(negedge axis_clk);
        axis_rst_n = 1;
        axil_read('h00, v, to);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL midsort_ctrl got %h expected 4", v); end
        axil_read('h10, v, to);
        checks++; if (v !== DEPTH) begin errors++; $display("FAIL midsort_len got %0d expected %0d", v, DEPTH); end
        run_random_job("after_rst", 5, 2'b10, 70);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_desc();
        test_early_tlast();
        test_len_regs();
        test_back_to_back();
        test_reset_mid_sort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
